// File: rtl/adc_reg_read.sv
// Read-back engine for the ADC/AD9512 SPI port: 16-bit read instruction out, 8-bit register value in.
// Optional build macro ADC_RD_4WIRE_EN: adds sdo_adc and keeps SDIO driven through the data phase.
module adc_reg_read #(
  parameter int SCLK_HALF = 1,
  parameter int ADDR_W    = 13
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] addr,
  output logic              sclk_adc,
  output logic              csb_adc,
  output logic              sdio_o,
  output logic              sdio_oe,
  input  logic              sdio_i,
`ifdef ADC_RD_4WIRE_EN
  input  logic              sdo_adc,
`endif
  output logic [7:0]        rd_data,
  output logic              data_valid,
  output logic              busy
);

  localparam logic [7:0] HALF_LAST = 8'(SCLK_HALF - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD    = 3'd1,
    TX_LOW  = 3'd2,
    TX_HIGH = 3'd3,
    RX_LOW  = 3'd4,
    RX_HIGH = 3'd5,
    DONE    = 3'd6
  } state_t;

  state_t      state, state_nx;
  logic [7:0]  hcnt, hcnt_nx;
  logic [4:0]  bcnt, bcnt_nx;
  logic [15:0] tx, tx_nx;
  logic [7:0]  rx, rx_nx;
  logic        half_end, rx_bit;
  logic [12:0] addr_field;
  logic        sclk_nx, csb_nx, sdio_o_nx, sdio_oe_nx, data_valid_nx, busy_nx;
  logic [7:0]  rd_data_nx;

  assign half_end   = (hcnt == HALF_LAST);
  assign addr_field = 13'(addr);

`ifdef ADC_RD_4WIRE_EN
  assign rx_bit = sdo_adc;
`else
  assign rx_bit = sdio_i;
`endif

  // State, counters, shift registers and registered pin outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      hcnt       <= 8'd0;
      bcnt       <= 5'd0;
      tx         <= 16'h0000;
      rx         <= 8'h00;
      sclk_adc   <= 1'b1;
      csb_adc    <= 1'b1;
      sdio_o     <= 1'b0;
      sdio_oe    <= 1'b0;
      rd_data    <= 8'h00;
      data_valid <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_nx;
      hcnt       <= hcnt_nx;
      bcnt       <= bcnt_nx;
      tx         <= tx_nx;
      rx         <= rx_nx;
      sclk_adc   <= sclk_nx;
      csb_adc    <= csb_nx;
      sdio_o     <= sdio_o_nx;
      sdio_oe    <= sdio_oe_nx;
      rd_data    <= rd_data_nx;
      data_valid <= data_valid_nx;
      busy       <= busy_nx;
    end
  end

  // Next-state logic; pin values are decoded from the next state so they are registered.
  always_comb begin
    state_nx = state;
    hcnt_nx  = 8'd0;
    bcnt_nx  = bcnt;
    tx_nx    = tx;
    rx_nx    = rx;
    case (state)
      IDLE: begin
        bcnt_nx = 5'd0;
        if (start) begin
          tx_nx    = {1'b1, 2'b00, addr_field};
          state_nx = LOAD;
        end else begin
          state_nx = IDLE;
        end
      end
      LOAD: begin
        bcnt_nx  = 5'd0;
        state_nx = TX_LOW;
      end
      TX_LOW, RX_LOW: begin
        if (half_end) begin
          state_nx = (state == TX_LOW) ? TX_HIGH : RX_HIGH;
        end else begin
          hcnt_nx = hcnt + 8'd1;
        end
      end
      TX_HIGH: begin
        if (half_end) begin
          tx_nx = {tx[14:0], 1'b0};
          if (bcnt == 5'd15) begin
            bcnt_nx  = 5'd0;
            state_nx = RX_LOW;
          end else begin
            bcnt_nx  = bcnt + 5'd1;
            state_nx = TX_LOW;
          end
        end else begin
          hcnt_nx = hcnt + 8'd1;
        end
      end
      RX_HIGH: begin
        if (half_end) begin
          rx_nx = {rx[6:0], rx_bit};
          if (bcnt == 5'd7) begin
            bcnt_nx  = 5'd0;
            state_nx = DONE;
          end else begin
            bcnt_nx  = bcnt + 5'd1;
            state_nx = RX_LOW;
          end
        end else begin
          hcnt_nx = hcnt + 8'd1;
        end
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase

    busy_nx = state_nx inside {LOAD, TX_LOW, TX_HIGH, RX_LOW, RX_HIGH};
    csb_nx  = ~busy_nx;
    sclk_nx = ~(state_nx inside {TX_LOW, RX_LOW});
    if (state_nx inside {TX_LOW, TX_HIGH}) begin
      sdio_o_nx = tx_nx[15];
    end else begin
      sdio_o_nx = 1'b0;
    end
`ifdef ADC_RD_4WIRE_EN
    sdio_oe_nx = busy_nx;
`else
    sdio_oe_nx = state_nx inside {TX_LOW, TX_HIGH};
`endif
    data_valid_nx = (state_nx == DONE);
    if (state_nx == DONE) begin
      rd_data_nx = rx_nx;
    end else begin
      rd_data_nx = rd_data;
    end
  end

endmodule

// File: tb/tb_adc_reg_read.sv
// Scoreboard bench for adc_reg_read: one instance at SCLK_HALF=1, one at SCLK_HALF=3, plus SPI device models.
module tb_adc_reg_read;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   n_pass = 0;
  int   n_total = 0;

  always #5 clk = ~clk;

  // Free-running edge counter used for latency measurements.
  always @(posedge clk) cyc <= cyc + 1;

  logic        start_a = 1'b0, start_b = 1'b0;
  logic [12:0] addr_a = 13'h0, addr_b = 13'h0;
  logic        sclk_a, csb_a, sdio_o_a, sdio_oe_a, dv_a, busy_a;
  logic        sclk_b, csb_b, sdio_o_b, sdio_oe_b, dv_b, busy_b;
  logic [7:0]  rd_a, rd_b;
  logic        sdio_i_a = 1'b0, sdio_i_b = 1'b0;
`ifdef ADC_RD_4WIRE_EN
  logic        sdo_a = 1'b0, sdo_b = 1'b0;
`endif

  adc_reg_read #(.SCLK_HALF(1), .ADDR_W(13)) dut_a (
    .clk(clk), .reset(reset), .start(start_a), .addr(addr_a),
    .sclk_adc(sclk_a), .csb_adc(csb_a), .sdio_o(sdio_o_a), .sdio_oe(sdio_oe_a),
    .sdio_i(sdio_i_a),
`ifdef ADC_RD_4WIRE_EN
    .sdo_adc(sdo_a),
`endif
    .rd_data(rd_a), .data_valid(dv_a), .busy(busy_a));

  adc_reg_read #(.SCLK_HALF(3), .ADDR_W(13)) dut_b (
    .clk(clk), .reset(reset), .start(start_b), .addr(addr_b),
    .sclk_adc(sclk_b), .csb_adc(csb_b), .sdio_o(sdio_o_b), .sdio_oe(sdio_oe_b),
    .sdio_i(sdio_i_b),
`ifdef ADC_RD_4WIRE_EN
    .sdo_adc(sdo_b),
`endif
    .rd_data(rd_b), .data_valid(dv_b), .busy(busy_b));

  // Device models: capture the instruction on sclk rises, return resp on falls after 16 rises.
  int          rises_a = 0, rises_b = 0;
  logic [15:0] cap_a = 16'h0, cap_b = 16'h0;
  logic [7:0]  resp_a = 8'h00, resp_b = 8'h00;
  bit          wire4 = 1'b0;
  logic [23:0] q_a[$];
  logic [23:0] q_b[$];

  always @(negedge csb_a) begin rises_a = 0; cap_a = 16'h0; end
  always @(posedge sclk_a) if (csb_a == 1'b0) begin
    if (rises_a < 16) cap_a = {cap_a[14:0], sdio_o_a};
    rises_a = rises_a + 1;
  end
  always @(negedge sclk_a) if (csb_a == 1'b0 && rises_a >= 16 && rises_a < 24) begin
    sdio_i_a = wire4 ? 1'($urandom_range(0, 1)) : resp_a[23 - rises_a];
`ifdef ADC_RD_4WIRE_EN
    sdo_a = resp_a[23 - rises_a];
`endif
  end

  always @(negedge csb_b) begin rises_b = 0; cap_b = 16'h0; end
  always @(posedge sclk_b) if (csb_b == 1'b0) begin
    if (rises_b < 16) cap_b = {cap_b[14:0], sdio_o_b};
    rises_b = rises_b + 1;
  end
  always @(negedge sclk_b) if (csb_b == 1'b0 && rises_b >= 16 && rises_b < 24) begin
    sdio_i_b = resp_b[23 - rises_b];
`ifdef ADC_RD_4WIRE_EN
    sdo_b = resp_b[23 - rises_b];
`endif
  end

  task automatic go_a(input logic [12:0] a);
    @(negedge clk);
    addr_a  = a;
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    n_total++; if (sclk_a !== 1'b1) $display("FAIL reset_sclk: got %b want 1", sclk_a); else n_pass++;
    n_total++; if (csb_a !== 1'b1) $display("FAIL reset_csb: got %b want 1", csb_a); else n_pass++;
    n_total++; if (sdio_oe_a !== 1'b0) $display("FAIL reset_oe: got %b want 0", sdio_oe_a); else n_pass++;
    n_total++; if (busy_a !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy_a); else n_pass++;
    n_total++; if (rd_a !== 8'h00) $display("FAIL reset_rd: got %h want 00", rd_a); else n_pass++;
    n_total++; if (dv_a !== 1'b0) $display("FAIL reset_dv: got %b want 0", dv_a); else n_pass++;
    n_total++; if ({sclk_b, csb_b, sdio_oe_b, busy_b, dv_b} !== 5'b11000)
      $display("FAIL reset_b: got %b want 11000", {sclk_b, csb_b, sdio_oe_b, busy_b, dv_b}); else n_pass++;
  endtask

  task automatic test_read_h1;
    int c0, oe_n, busy_n, dv_n, dv_off, bad_o;
    logic [7:0] got; logic [15:0] gcap; logic [23:0] exp_v;
    resp_a = 8'hA5; wire4 = 1'b0;
    q_a.push_back({16'h8045, 8'hA5});
    go_a(13'h045);
    c0 = cyc; oe_n = 0; busy_n = 0; dv_n = 0; dv_off = -1; bad_o = 0; got = 8'h00; gcap = 16'h0;
    for (int i = 0; i < 120; i++) begin
      if (sdio_oe_a) oe_n++;
      if (busy_a) busy_n++;
      if (!sdio_oe_a && sdio_o_a) bad_o++;
      if (dv_a) begin dv_n++; dv_off = cyc - c0; got = rd_a; gcap = cap_a; end
      @(negedge clk);
    end
    n_total++; if (oe_n != 32) $display("FAIL h1_oe_cycles: got %0d want 32", oe_n); else n_pass++;
    n_total++; if (busy_n != 49) $display("FAIL h1_busy_cycles: got %0d want 49", busy_n); else n_pass++;
    n_total++; if (dv_n != 1) $display("FAIL h1_dv_count: got %0d want 1", dv_n); else n_pass++;
    // Offset 49 from the first busy cycle (N+1) is cycle N+50.
    n_total++; if (dv_off != 49) $display("FAIL h1_dv_latency: got %0d want 49", dv_off); else n_pass++;
    n_total++; if (bad_o != 0) $display("FAIL h1_sdio_o_idle: got %0d want 0", bad_o); else n_pass++;
    n_total++;
    if (q_a.size() == 0) $display("FAIL h1_scoreboard: got empty want 1 entry");
    else begin
      exp_v = q_a.pop_front();
      if (got !== exp_v[7:0] || gcap !== exp_v[23:8])
        $display("FAIL h1_read: got rd=%h instr=%h want rd=%h instr=%h", got, gcap, exp_v[7:0], exp_v[23:8]);
      else n_pass++;
    end
  endtask

  task automatic test_read_h3;
    int c0, oe_n, dv_n, dv_off, r1, r2; logic prev;
    logic [7:0] got; logic [15:0] gcap; logic [23:0] exp_v;
    resp_b = 8'h00;
    q_b.push_back({16'h9FFF, 8'h00});
    @(negedge clk); addr_b = 13'h1FFF; start_b = 1'b1;
    @(negedge clk); start_b = 1'b0;
    c0 = cyc; oe_n = 0; dv_n = 0; dv_off = -1; r1 = -1; r2 = -1; prev = 1'b1; got = 8'hFF; gcap = 16'h0;
    for (int i = 0; i < 220; i++) begin
      if (sdio_oe_b) oe_n++;
      if (sclk_b && !prev && !csb_b) begin
        if (r1 < 0) r1 = cyc; else if (r2 < 0) r2 = cyc;
      end
      prev = sclk_b;
      if (dv_b) begin dv_n++; dv_off = cyc - c0; got = rd_b; gcap = cap_b; end
      @(negedge clk);
    end
    n_total++; if (r2 - r1 != 6) $display("FAIL h3_sclk_period: got %0d want 6", r2 - r1); else n_pass++;
    n_total++; if (oe_n != 96) $display("FAIL h3_oe_cycles: got %0d want 96", oe_n); else n_pass++;
    n_total++; if (dv_n != 1) $display("FAIL h3_dv_count: got %0d want 1", dv_n); else n_pass++;
    n_total++; if (dv_off != 145) $display("FAIL h3_dv_latency: got %0d want 145", dv_off); else n_pass++;
    n_total++;
    if (q_b.size() == 0) $display("FAIL h3_scoreboard: got empty want 1 entry");
    else begin
      exp_v = q_b.pop_front();
      if (got !== exp_v[7:0] || gcap !== exp_v[23:8])
        $display("FAIL h3_read: got rd=%h instr=%h want rd=%h instr=%h", got, gcap, exp_v[7:0], exp_v[23:8]);
      else n_pass++;
    end
  endtask

  task automatic test_ignore_start;
    int windows, dv_n; logic prev;
    logic [7:0] got; logic [15:0] gcap; logic [23:0] exp_v;
    resp_a = 8'h3E;
    q_a.push_back({16'h8123, 8'h3E});
    go_a(13'h123);
    windows = 0; dv_n = 0; prev = 1'b1; got = 8'h00; gcap = 16'h0;
    for (int i = 0; i < 120; i++) begin
      if (!csb_a && prev) windows++;
      prev = csb_a;
      if (dv_a) begin dv_n++; got = rd_a; gcap = cap_a; end
      if (i == 9) begin start_a = 1'b1; addr_a = 13'h0AA; end
      if (i == 10) start_a = 1'b0;
      @(negedge clk);
    end
    n_total++; if (windows != 1) $display("FAIL ignore_csb_windows: got %0d want 1", windows); else n_pass++;
    n_total++; if (dv_n != 1) $display("FAIL ignore_dv_count: got %0d want 1", dv_n); else n_pass++;
    n_total++;
    if (q_a.size() == 0) $display("FAIL ignore_scoreboard: got empty want 1 entry");
    else begin
      exp_v = q_a.pop_front();
      if (got !== exp_v[7:0] || gcap !== exp_v[23:8])
        $display("FAIL ignore_read: got rd=%h instr=%h want rd=%h instr=%h", got, gcap, exp_v[7:0], exp_v[23:8]);
      else n_pass++;
    end
  endtask

  task automatic test_back_to_back;
    int dv_n, gap, phase; logic [23:0] exp_v;
    resp_a = 8'h5A;
    q_a.push_back({16'h80F0, 8'h5A});
    q_a.push_back({16'h80F0, 8'h5A});
    @(negedge clk); addr_a = 13'h0F0; start_a = 1'b1;
    dv_n = 0; gap = 0; phase = 0;
    for (int i = 0; i < 160; i++) begin
      if (dv_a) begin
        if (dv_n == 0) phase = 1;
        dv_n++;
        n_total++;
        if (q_a.size() == 0) $display("FAIL b2b_scoreboard: got empty want entry");
        else begin
          exp_v = q_a.pop_front();
          if (rd_a !== exp_v[7:0] || cap_a !== exp_v[23:8])
            $display("FAIL b2b_read: got rd=%h instr=%h want rd=%h instr=%h", rd_a, cap_a, exp_v[7:0], exp_v[23:8]);
          else n_pass++;
        end
      end
      if (phase == 1) begin
        if (csb_a) gap++;
        else begin phase = 2; start_a = 1'b0; end
      end
      @(negedge clk);
    end
    start_a = 1'b0;
    n_total++; if (gap != 2) $display("FAIL b2b_csb_gap: got %0d want 2", gap); else n_pass++;
    n_total++; if (dv_n != 2) $display("FAIL b2b_dv_count: got %0d want 2", dv_n); else n_pass++;
  endtask

  task automatic test_reset_mid;
    int dv_n, waited;
    resp_a = 8'hC3;
    go_a(13'h0300);
    waited = 0;
    while (rises_a < 20 && waited < 100) begin @(negedge clk); waited++; end
    n_total++; if (rises_a < 20) $display("FAIL mid_reach_rx: got %0d want 20 sclk rises", rises_a); else n_pass++;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    n_total++; if ({csb_a, sclk_a, sdio_oe_a, busy_a, dv_a} !== 5'b11000)
      $display("FAIL mid_pins: got %b want 11000", {csb_a, sclk_a, sdio_oe_a, busy_a, dv_a}); else n_pass++;
    n_total++; if (rd_a !== 8'h00) $display("FAIL mid_rd_clear: got %h want 00", rd_a); else n_pass++;
    dv_n = 0;
    for (int i = 0; i < 60; i++) begin
      if (dv_a) dv_n++;
      @(negedge clk);
    end
    n_total++; if (dv_n != 0) $display("FAIL mid_no_dv: got %0d want 0", dv_n); else n_pass++;
  endtask

`ifdef ADC_RD_4WIRE_EN
  task automatic test_4wire;
    int oe_n, bad_o; logic dv_oe; logic [7:0] got; logic [23:0] exp_v;
    resp_a = 8'h3C; wire4 = 1'b1;
    q_a.push_back({16'h8010, 8'h3C});
    go_a(13'h010);
    oe_n = 0; bad_o = 0; dv_oe = 1'b1; got = 8'h00;
    for (int i = 0; i < 120; i++) begin
      if (sdio_oe_a) oe_n++;
      if (rises_a >= 16 && sdio_o_a) bad_o++;
      if (dv_a) begin dv_oe = sdio_oe_a; got = rd_a; end
      @(negedge clk);
    end
    wire4 = 1'b0;
    n_total++; if (oe_n != 49) $display("FAIL w4_oe_cycles: got %0d want 49", oe_n); else n_pass++;
    n_total++; if (dv_oe !== 1'b0) $display("FAIL w4_oe_done: got %b want 0", dv_oe); else n_pass++;
    n_total++; if (bad_o != 0) $display("FAIL w4_sdio_o_rx: got %0d want 0", bad_o); else n_pass++;
    n_total++;
    if (q_a.size() == 0) $display("FAIL w4_scoreboard: got empty want 1 entry");
    else begin
      exp_v = q_a.pop_front();
      if (got !== exp_v[7:0]) $display("FAIL w4_read: got %h want %h", got, exp_v[7:0]);
      else n_pass++;
    end
  endtask
`endif

  initial begin
    test_reset();
    test_read_h1();
    test_read_h3();
    test_ignore_start();
    test_back_to_back();
    test_reset_mid();
`ifdef ADC_RD_4WIRE_EN
    test_4wire();
`endif
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
